// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
// Bundles every handshake/bus signal of the instruction-fetch stage so the
// stage and its surroundings connect through a single port.
//   PC stage   : i_pc, i_pc_valid -> fetch, o_pc_ready <- fetch
//   IMEM bus   : o_imem_req, o_imem_addr <- fetch,
//                i_imem_gnt, i_imem_rvalid, i_imem_rdata -> fetch
//   Redirect   : i_flush -> fetch
//   IF/ID      : o_id_valid, o_id_pc, o_id_inst <- fetch, i_id_ready -> fetch
// Signal prefixes (i_/o_) are from the fetch stage's point of view.
// modport slave  : the fetch stage itself
// modport master : everything around it (PC stage, memory, EX, decode)
// ---------------------------------------------------------------------------
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] i_pc;
  logic              i_pc_valid;
  logic              o_pc_ready;
  logic              o_imem_req;
  logic [ADDR_W-1:0] o_imem_addr;
  logic              i_imem_gnt;
  logic              i_imem_rvalid;
  logic [DATA_W-1:0] i_imem_rdata;
  logic              i_flush;
  logic              o_id_valid;
  logic              i_id_ready;
  logic [ADDR_W-1:0] o_id_pc;
  logic [DATA_W-1:0] o_id_inst;

  modport slave (
    input  i_pc, i_pc_valid, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
           i_flush, i_id_ready,
    output o_pc_ready, o_imem_req, o_imem_addr, o_id_valid, o_id_pc,
           o_id_inst
  );

  modport master (
    output i_pc, i_pc_valid, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
           i_flush, i_id_ready,
    input  o_pc_ready, o_imem_req, o_imem_addr, o_id_valid, o_id_pc,
           o_id_inst
  );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage. Accepts fetch addresses from the PC stage,
// issues them to instruction memory (req/gnt, in-order rvalid), pairs each
// returned instruction with its address and queues the pairs in order for
// the IF/ID boundary. A flush empties the queue and arranges for responses
// still in flight to be thrown away.
// Ports:
//   clk  : clock
//   rstn : asynchronous, active-low reset
//   bus  : if_fetch_if.slave (PC handshake, IMEM bus, flush, IF/ID output)
// Parameters:
//   ADDR_W, DATA_W : address / instruction width
//   DEPTH          : max outstanding requests + queued entries (power of 2)
//   NOP_INST       : instruction presented while the queue is empty
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic       clk,
  input  logic       rstn,
  if_fetch_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Occupancy counters
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_discard;
  logic [CW-1:0]     r_q_count;

  // Address FIFO: addresses of granted requests awaiting their response
  logic [AW-1:0]     r_af_wr;
  logic [AW-1:0]     r_af_rd;
  logic [ADDR_W-1:0] r_af_mem [DEPTH];

  // Output queue of {pc, instruction} pairs
  logic [AW-1:0]     r_q_wr;
  logic [AW-1:0]     r_q_rd;
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];
  logic [DATA_W-1:0] r_q_inst [DEPTH];
  logic [ADDR_W-1:0] r_last_pc;

  logic [CW:0]       w_credit_sum;
  logic              w_credit_ok;
  logic              w_req;
  logic              w_grant;
  logic              w_resp;
  logic              w_drop;
  logic              w_q_empty;
  logic              w_q_push;
  logic              w_q_pop;
  logic [CW-1:0]     w_out_next;

  // Credits cover both in-flight requests and queued entries, so every
  // response always has a queue slot waiting for it.
  assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, r_q_count};
  assign w_credit_ok  = w_credit_sum < DEPTH_C;

  assign w_req   = rstn && bus.i_pc_valid && w_credit_ok && !bus.i_flush;
  assign w_grant = w_req && bus.i_imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp  = bus.i_imem_rvalid && (r_outstanding != '0);
  assign w_drop  = (r_discard != '0);

  assign w_q_empty = (r_q_count == '0);
  assign w_q_push  = w_resp && !w_drop && !bus.i_flush;
  assign w_q_pop   = !w_q_empty && bus.i_id_ready && !bus.i_flush;

  assign w_out_next = r_outstanding + CW'(w_grant) - CW'(w_resp);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_outstanding <= '0;
      r_discard     <= '0;
      r_q_count     <= '0;
      r_af_wr       <= '0;
      r_af_rd       <= '0;
      r_q_wr        <= '0;
      r_q_rd        <= '0;
      r_last_pc     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_grant) r_af_wr <= r_af_wr + 1'b1;
      // Discarded responses still retire their address FIFO entry.
      if (w_resp)  r_af_rd <= r_af_rd + 1'b1;

      if (bus.i_flush) begin
        // Everything still outstanding after this cycle belongs to the
        // wrong path; a grant cannot coincide since req is blocked.
        r_discard <= w_out_next;
        r_q_count <= '0;
        r_q_wr    <= '0;
        r_q_rd    <= '0;
      end else begin
        if (w_resp && w_drop) r_discard <= r_discard - 1'b1;
        if (w_q_push) r_q_wr <= r_q_wr + 1'b1;
        if (w_q_pop)  r_q_rd <= r_q_rd + 1'b1;
        r_q_count <= r_q_count + CW'(w_q_push) - CW'(w_q_pop);
      end

      // Remember the head address so id_pc holds it once the queue drains.
      if (!w_q_empty) r_last_pc <= r_q_pc[r_q_rd];
    end
  end

  // Storage arrays need no reset: pointers and counts qualify their contents.
  always_ff @(posedge clk) begin
    if (w_grant) r_af_mem[r_af_wr] <= bus.i_pc;
    if (w_q_push) begin
      r_q_pc[r_q_wr]   <= r_af_mem[r_af_rd];
      r_q_inst[r_q_wr] <= bus.i_imem_rdata;
    end
  end

  assign bus.o_imem_req  = w_req;
  assign bus.o_imem_addr = {bus.i_pc[ADDR_W-1:2], 2'b00};
  assign bus.o_pc_ready  = w_grant;
  assign bus.o_id_valid  = !w_q_empty;
  assign bus.o_id_pc     = w_q_empty ? r_last_pc : r_q_pc[r_q_rd];
  assign bus.o_id_inst   = w_q_empty ? NOP_INST  : r_q_inst[r_q_rd];

endmodule
